// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues fetch addresses to the instruction cache,
// tracks the single outstanding request, absorbs cache misses, decode
// back-pressure and branch/jump redirects, and owns the IF/ID register.
//
// Handshake contract with the cache: the value on icache_addr at a rising
// edge is the request. Its word shows up on icache_inst in the first later
// cycle that has icache_stall=0. While icache_stall=1, icache_addr always
// shows the missed address (req_pc), so the refill logic sees a stable
// request. IF/ID is held whenever hazard_stall=1 and nothing higher
// priority (redirect, kill, miss bubble) overrides it.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] icache_addr,
  input  logic [31:0] icache_inst,
  input  logic        icache_stall,
  input  logic        hazard_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_inst,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_KILL  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc_f, pc_f_nx;
  logic [31:0] req_pc, req_pc_nx;
  logic        req_valid, req_valid_nx;
  logic [31:0] tgt, tgt_nx;
  logic        id_load;
  logic        id_clear;
  logic        resp;
  logic [31:0] redir;

  // Redirect targets are word addresses; the low two bits are dropped.
  assign redir     = redirect_pc & 32'hFFFF_FFFC;
  assign resp      = req_valid & ~icache_stall;
  assign fsm_state = state;

  // Next-state, next-request and cache address selection, in priority order:
  // redirect, kill drain, cache stall, boot, hazard replay, normal advance.
  always_comb begin
    state_nx     = state;
    pc_f_nx      = pc_f;
    req_pc_nx    = req_pc;
    req_valid_nx = req_valid;
    tgt_nx       = tgt;
    icache_addr  = pc_f;
    id_load      = 1'b0;
    id_clear     = 1'b0;

    if (redirect_valid && icache_stall) begin
      // Cannot re-aim the cache mid-refill: remember the target and wait.
      tgt_nx      = redir;
      id_clear    = 1'b1;
      state_nx    = ST_KILL;
      icache_addr = req_pc;
    end else if (redirect_valid) begin
      // Whatever response arrives this cycle belongs to the wrong path.
      icache_addr  = redir;
      req_pc_nx    = redir;
      req_valid_nx = 1'b1;
      pc_f_nx      = redir + 32'd4;
      id_clear     = 1'b1;
      state_nx     = ST_FETCH;
    end else if (state == ST_KILL) begin
      if (icache_stall) begin
        icache_addr = req_pc;
      end else begin
        // Stale refill word is dropped; issue the deferred target.
        icache_addr  = tgt;
        req_pc_nx    = tgt;
        req_valid_nx = 1'b1;
        pc_f_nx      = tgt + 32'd4;
        state_nx     = ST_FETCH;
      end
    end else if (icache_stall) begin
      icache_addr = req_pc;
      // Insert a bubble unless decode wants IF/ID held anyway.
      if (state == ST_FETCH && !hazard_stall) begin
        id_clear = 1'b1;
      end
    end else if (state == ST_BOOT) begin
      icache_addr  = pc_f;
      req_pc_nx    = pc_f;
      req_valid_nx = 1'b1;
      pc_f_nx      = pc_f + 32'd4;
      state_nx     = ST_FETCH;
    end else if (hazard_stall || !resp) begin
      // Decode is full: drop the response and ask for the same word again.
      icache_addr = req_pc;
    end else begin
      icache_addr = pc_f;
      req_pc_nx   = pc_f;
      pc_f_nx     = pc_f + 32'd4;
      id_load     = 1'b1;
    end
  end

  // FSM and request tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_BOOT;
      pc_f      <= RESET_PC;
      req_pc    <= 32'd0;
      req_valid <= 1'b0;
      tgt       <= 32'd0;
    end else begin
      state     <= state_nx;
      pc_f      <= pc_f_nx;
      req_pc    <= req_pc_nx;
      req_valid <= req_valid_nx;
      tgt       <= tgt_nx;
    end
  end

  // IF/ID pipeline register: a clear always wins over a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_inst  <= 32'd0;
    end else if (id_clear) begin
      if_id_valid <= 1'b0;
    end else if (id_load) begin
      if_id_valid <= 1'b1;
      if_id_pc    <= req_pc;
      if_id_pc4   <= req_pc + 32'd4;
      if_id_inst  <= icache_inst;
    end
  end

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (id_load) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (icache_stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural cache model feeds a directed sequence
// followed by randomized miss/hazard/redirect traffic; a reference model of
// the instruction stream predicts every observable each cycle.
module tb_fetch_stage;

  localparam logic [31:0] RESET0 = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] icache_addr, icache_inst, redirect_pc;
  logic        icache_stall = 1'b0, hazard_stall = 1'b0, redirect_valid = 1'b0;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_pc4, if_id_inst, perf_fetch_cnt, perf_stall_cnt;
  logic [1:0]  fsm_state;
  logic [31:0] junk_word = 32'hDEAD_BEEF;
  logic [31:0] lat_addr = 32'd0;

  // Second instance: wrap-around reset vector, always-hitting cache.
  logic [31:0] addr2, inst2, pc2, pc42, inst_id2, fcnt2, scnt2;
  logic        valid2;
  logic [1:0]  state2;
  logic [31:0] lat_addr2 = 32'd0;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Cache model: capture the request at each edge, return its word later.
  always @(posedge clk) lat_addr  <= icache_addr;
  always @(posedge clk) lat_addr2 <= addr2;
  assign icache_inst = icache_stall ? junk_word : mem_word(lat_addr);
  assign inst2       = mem_word(lat_addr2);

  fetch_stage #(.RESET_PC(RESET0)) dut (
    .clk(clk), .rst(rst),
    .icache_addr(icache_addr), .icache_inst(icache_inst),
    .icache_stall(icache_stall), .hazard_stall(hazard_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_inst(if_id_inst), .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt), .fsm_state(fsm_state)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .icache_addr(addr2), .icache_inst(inst2),
    .icache_stall(1'b0), .hazard_stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'd0),
    .if_id_valid(valid2), .if_id_pc(pc2), .if_id_pc4(pc42),
    .if_id_inst(inst_id2), .perf_fetch_cnt(fcnt2),
    .perf_stall_cnt(scnt2), .fsm_state(state2)
  );

  // ---------------- reference model ----------------
  // m_want: address of the word owed to decode (next sequential is +4).
  bit          m_boot, m_kill, m_v;
  logic [31:0] m_want, m_tgt, m_pc, m_pc4, m_inst, m_fetches, m_stalls;

  task automatic model_reset();
    m_boot = 1'b1; m_kill = 1'b0; m_v = 1'b0;
    m_want = 32'd0; m_tgt = 32'd0; m_pc = 32'd0; m_pc4 = 32'd0;
    m_inst = 32'd0; m_fetches = 32'd0; m_stalls = 32'd0;
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: entered at a falling edge, drives inputs, checks every
  // observable against the model, advances the model, waits one cycle.
  task automatic step(input bit st, input bit hz, input bit rv, input logic [31:0] rp);
    logic [31:0] r, e_addr;
    icache_stall = st; hazard_stall = hz; redirect_valid = rv; redirect_pc = rp;
    junk_word = $urandom;
    #1;
    r = rp & 32'hFFFF_FFFC;
    if (st)          e_addr = m_want;
    else if (rv)     e_addr = r;
    else if (m_kill) e_addr = m_tgt;
    else if (m_boot) e_addr = RESET0;
    else if (hz)     e_addr = m_want;
    else             e_addr = m_want + 32'd4;
    check("icache_addr", icache_addr, e_addr);
    check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_v});
    check("if_id_pc", if_id_pc, m_pc);
    check("if_id_pc4", if_id_pc4, m_pc4);
    check("if_id_inst", if_id_inst, m_inst);
    check("perf_fetch", perf_fetch_cnt, m_fetches);
    check("perf_stall", perf_stall_cnt, m_stalls);
    if (st) m_stalls = m_stalls + 32'd1;
    if (rv && st) begin
      m_tgt = r; m_kill = 1'b1; m_boot = 1'b0; m_v = 1'b0;
    end else if (rv) begin
      m_want = r; m_kill = 1'b0; m_boot = 1'b0; m_v = 1'b0;
    end else if (m_kill) begin
      if (!st) begin m_want = m_tgt; m_kill = 1'b0; end
    end else if (st) begin
      if (!hz) m_v = 1'b0;
    end else if (m_boot) begin
      m_want = RESET0; m_boot = 1'b0;
    end else if (!hz) begin
      m_v = 1'b1; m_pc = m_want; m_pc4 = m_want + 32'd4; m_inst = mem_word(m_want);
      m_fetches = m_fetches + 32'd1; m_want = m_want + 32'd4;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle, optionally during a miss.
  task automatic do_reset(input bit mid_stall);
    icache_stall = mid_stall; hazard_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", {31'b0, if_id_valid}, 32'd0);
    check("rst_async_fetch", perf_fetch_cnt, 32'd0);
    check("rst_async_stall", perf_stall_cnt, 32'd0);
    check("rst_state", {30'b0, fsm_state}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; icache_stall = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rp;
    model_reset();
    @(negedge clk);
    do_reset(1'b0);

    // Reset release, all hits; wrap-around reset vector on u_wrap.
    check("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    check("wrap_second_addr", addr2, 32'h0000_0000);
    step(0, 0, 0, 0);
    check("wrap_valid", {31'b0, valid2}, 32'd1);
    check("wrap_pc", pc2, 32'hFFFF_FFFC);
    check("wrap_pc4", pc42, 32'h0000_0000);
    check("wrap_inst", inst_id2, mem_word(32'hFFFF_FFFC));
    check("wrap_fcnt", fcnt2, 32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("boot_fetch_cnt", perf_fetch_cnt, 32'd3);
    check("boot_pc8", if_id_pc, 32'h8);

    // Decode back-pressure for two cycles.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("hazard_hold_pc", if_id_pc, 32'h8);
    step(0, 0, 0, 0);
    check("hazard_release_pc", if_id_pc, 32'hC);

    // Miss on 0x10 for three cycles.
    step(1, 0, 0, 0);
    check("miss_addr", icache_addr, 32'h10);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("miss_pc", if_id_pc, 32'h10);
    check("miss_stall_cnt", perf_stall_cnt, 32'd3);

    // Redirect during a hit (unaligned target bits ignored).
    step(0, 0, 1, 32'h101);
    check("redir_bubble", {31'b0, if_id_valid}, 32'd0);
    step(0, 0, 0, 0);
    check("redir_pc", if_id_pc, 32'h100);

    // Redirect while stalled: kill the refill word.
    step(1, 0, 1, 32'h202);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("kill_no_stale", {31'b0, if_id_valid}, 32'd0);
    step(0, 0, 0, 0);
    check("kill_pc", if_id_pc, 32'h200);

    // Randomized traffic with resets dropped in mid-miss.
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 500; i++) begin
        rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
        step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
             $urandom_range(0, 99) < 6, rp);
      end
      icache_stall = 1'b1;
      do_reset(1'b1);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish before 1000000");
    $fatal(1);
  end

endmodule
